// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: collects finished results from the functional
// units, grants one FU per cycle by round-robin, and registers the winning
// result onto the CDB that feeds the ROB, reservation stations and regfile.
//
// Handshake: an FU raises fu_done[i] with fu_data[i] and holds both stable
// until it sees cdb_ack[i] high at a clk edge. On that same edge the arbiter
// captures fu_data[i]. The FU drops fu_done[i] in the following cycle.

package cdb_pkg;

    // Result record broadcast on the CDB. The arbiter never looks inside it.
    typedef struct packed {
        logic [5:0]  pd_s;       // physical destination register
        logic [4:0]  rob_num;    // ROB entry of the producing instruction
        logic [31:0] pd_v;       // result value
        logic        br_en;      // branch taken
        logic [31:0] br_target;  // branch target
        logic [63:0] rvfi_data;  // retirement trace payload
    } fu_cdb_data_t;

endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_FU = 4,
    localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_mispredict,
    input  logic [NUM_FU-1:0]        fu_done,
    input  fu_cdb_data_t [NUM_FU-1:0] fu_data,
    output logic [NUM_FU-1:0]        cdb_ack,
    output logic                     cdb_valid,
    output fu_cdb_data_t             cdb_data,
    output logic [PTR_W-1:0]         cdb_src,
    output logic [PTR_W-1:0]         dbg_rr_ptr
);

    // Index arithmetic is done one bit wider so ptr + offset never overflows
    // before the modulo-NUM_FU fold.
    localparam logic [PTR_W:0]   NUM_FU_W = (PTR_W + 1)'(NUM_FU);
    localparam logic [PTR_W-1:0] LAST_FU  = PTR_W'(NUM_FU - 1);

    // Architectural state
    logic [PTR_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic             cdb_valid_q, cdb_valid_d;
    fu_cdb_data_t     cdb_data_q,  cdb_data_d;
    logic [PTR_W-1:0] cdb_src_q,   cdb_src_d;

    // Grant datapath
    logic [PTR_W:0]   cand;
    logic             found;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_v;
    logic [PTR_W-1:0] ptr_after_grant;

    // Round-robin scan of fu_done starting at rr_ptr, wrapping modulo NUM_FU.
    always_comb begin
        cand      = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (cand >= NUM_FU_W) begin
                cand = cand - NUM_FU_W;
            end
            if (!found && fu_done[cand[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    // A grant is suppressed while reset or a mispredict flush is in progress,
    // so pending results are discarded rather than acked.
    assign grant_v = found && !rst && !branch_mispredict;

    // Pointer moves just past the winner; explicit wrap keeps it below NUM_FU
    // even when NUM_FU is not a power of two.
    assign ptr_after_grant = (grant_idx == LAST_FU) ? '0 : grant_idx + PTR_W'(1);

    // One-hot acknowledge to the winning FU, same cycle as its fu_done.
    always_comb begin
        cdb_ack = '0;
        if (grant_v) begin
            cdb_ack[grant_idx] = 1'b1;
        end
    end

    // Next-state: capture the winner on a grant edge, otherwise hold data/ptr
    // and drop valid (covers idle and mispredict edges alike).
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (grant_v) begin
            rr_ptr_d    = ptr_after_grant;
            cdb_valid_d = 1'b1;
            cdb_data_d  = fu_data[grant_idx];
            cdb_src_d   = grant_idx;
        end
    end

    // State registers with synchronous reset; reset dominates a mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_data   = cdb_data_q;
    assign cdb_src    = cdb_src_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, a hand-written single-grant
// sequence, then randomized traffic checked against a round-robin model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N = 4;
    localparam int W = $bits(fu_cdb_data_t);

    // clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  branch_mispredict;
    logic [N-1:0]          fu_done;
    fu_cdb_data_t [N-1:0]  fu_data;
    logic [N-1:0]          cdb_ack;
    logic                  cdb_valid;
    fu_cdb_data_t          cdb_data;
    logic [1:0]            cdb_src;
    logic [1:0]            dbg_rr_ptr;

    cdb_arbiter #(.NUM_FU(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .branch_mispredict (branch_mispredict),
        .fu_done           (fu_done),
        .fu_data           (fu_data),
        .cdb_ack           (cdb_ack),
        .cdb_valid         (cdb_valid),
        .cdb_data          (cdb_data),
        .cdb_src           (cdb_src),
        .dbg_rr_ptr        (dbg_rr_ptr)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Distinct, recognisable payload per FU and per vector.
    function automatic fu_cdb_data_t mk_data(input int i, input int tag);
        fu_cdb_data_t d;
        logic [31:0] ii, tt;
        ii = 32'(i);
        tt = 32'(tag);
        d.pd_s      = 6'(i * 7 + tag);
        d.rob_num   = tt[4:0];
        d.pd_v      = 32'hA500_0000 | (ii << 12) | tt;
        d.br_en     = tt[0] ^ ii[0];
        d.br_target = {tt[15:0], ii[15:0]};
        d.rvfi_data = {ii, ~tt};
        return d;
    endfunction

    typedef struct {
        logic       rst;
        logic       mp;
        logic [3:0] done;
        logic [3:0] exp_ack;
        logic       exp_valid;
        logic [1:0] exp_src;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs[18];

    // model state for random phase
    logic [W-1:0] exp_q[$];
    logic         pending [N];
    fu_cdb_data_t pdata   [N];

    initial begin
        rst = 1'b1;
        branch_mispredict = 1'b0;
        fu_done = '0;
        fu_data = '0;

        //          rst  mp   done     ack      v     src   ptr
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 4'b1110, 4'b0010, 1'b1, 2'd1, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 4'b1101, 4'b0100, 1'b1, 2'd2, 2'd3};
        vecs[6]  = '{1'b0, 1'b0, 4'b1011, 4'b1000, 1'b1, 2'd3, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'b0111, 4'b0001, 1'b1, 2'd0, 2'd1};
        vecs[8]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 2'd3};
        vecs[9]  = '{1'b0, 1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 2'd1};
        vecs[11] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0, 2'd1};
        vecs[13] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 2'd2};
        vecs[14] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1, 2'd2};
        vecs[15] = '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 2'd0};
        vecs[16] = '{1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0, 2'd0};
        vecs[17] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 2'd2};

        // ---------------- directed table ----------------
        for (int v = 0; v < 18; v++) begin
            @(negedge clk);
            rst = vecs[v].rst;
            branch_mispredict = vecs[v].mp;
            fu_done = vecs[v].done;
            for (int i = 0; i < N; i++) fu_data[i] = mk_data(i, v);
            #1;
            chk($sformatf("v%0d ack", v), 32'(cdb_ack), 32'(vecs[v].exp_ack));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", v), 32'(cdb_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d src", v), 32'(cdb_src), 32'(vecs[v].exp_src));
            chk($sformatf("v%0d ptr", v), 32'(dbg_rr_ptr), 32'(vecs[v].exp_ptr));
            if (vecs[v].exp_valid)
                chk_data($sformatf("v%0d data", v), cdb_data, mk_data(int'(vecs[v].exp_src), v));
            if (vecs[v].rst)
                chk_data($sformatf("v%0d rst data", v), cdb_data, '0);
        end

        // ---------------- single FU2 grant ----------------
        @(negedge clk);
        rst = 1'b1; branch_mispredict = 1'b0; fu_done = '0; fu_data = '0;
        @(negedge clk);
        rst = 1'b0;
        fu_done = 4'b0100;
        fu_data[2] = mk_data(2, 99);
        fu_data[2].pd_v = 32'hDEAD_BEEF;
        #1;
        chk("fu2 ack", 32'(cdb_ack), 32'h4);
        @(posedge clk);
        #1;
        chk("fu2 valid", 32'(cdb_valid), 32'h1);
        chk("fu2 pd_v", cdb_data.pd_v, 32'hDEAD_BEEF);
        chk("fu2 src", 32'(cdb_src), 32'd2);
        chk("fu2 ptr", 32'(dbg_rr_ptr), 32'd3);
        @(negedge clk);
        fu_done = '0;
        #1;
        chk("fu2 idle ack", 32'(cdb_ack), 32'h0);
        @(posedge clk);
        #1;
        chk("fu2 idle valid", 32'(cdb_valid), 32'h0);
        chk("fu2 idle ptr", 32'(dbg_rr_ptr), 32'd3);
        chk("fu2 idle pd_v held", cdb_data.pd_v, 32'hDEAD_BEEF);

        // ---------------- randomized vs model ----------------
        begin
            int m_ptr;
            logic m_valid;
            int m_src;
            int g;
            logic r_rst, r_mp;
            logic [159:0] r;
            logic [W-1:0] e;

            @(negedge clk);
            rst = 1'b1; branch_mispredict = 1'b0; fu_done = '0;
            @(posedge clk);
            m_ptr = 0; m_valid = 1'b0; m_src = 0;
            for (int i = 0; i < N; i++) begin
                pending[i] = 1'b0;
                pdata[i] = '0;
            end

            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                r_rst = ($urandom_range(0, 99) < 3);
                r_mp  = ($urandom_range(0, 99) < 8);
                for (int i = 0; i < N; i++) begin
                    if (!pending[i] && $urandom_range(0, 99) < 55) begin
                        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
                        pending[i] = 1'b1;
                        pdata[i] = fu_cdb_data_t'(r[W-1:0]);
                    end
                    fu_done[i] = pending[i];
                    fu_data[i] = pdata[i];
                end
                rst = r_rst;
                branch_mispredict = r_mp;

                // winner: first pending FU scanning from the pointer
                g = -1;
                if (!r_rst && !r_mp) begin
                    for (int k = 0; k < N; k++) begin
                        if (g < 0 && pending[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    end
                end
                #1;
                chk($sformatf("rnd%0d ack", cyc), 32'(cdb_ack), (g < 0) ? 32'h0 : (32'h1 << g));

                @(posedge clk);
                #1;
                if (r_rst) begin
                    m_ptr = 0; m_valid = 1'b0; m_src = 0;
                    exp_q.delete();
                    for (int i = 0; i < N; i++) pending[i] = 1'b0;
                end else if (r_mp) begin
                    m_valid = 1'b0;
                    for (int i = 0; i < N; i++) pending[i] = 1'b0;
                end else if (g >= 0) begin
                    exp_q.push_back(pdata[g]);
                    pending[g] = 1'b0;
                    m_ptr = (g + 1) % N;
                    m_src = g;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end

                chk($sformatf("rnd%0d valid", cyc), 32'(cdb_valid), 32'(m_valid));
                chk($sformatf("rnd%0d ptr", cyc), 32'(dbg_rr_ptr), 32'(m_ptr));
                chk($sformatf("rnd%0d src", cyc), 32'(cdb_src), 32'(m_src));
                if (r_rst) chk_data($sformatf("rnd%0d rst data", cyc), cdb_data, '0);
                if (m_valid && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_data($sformatf("rnd%0d data", cyc), cdb_data, e);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
